vga_scanout: RTL and testbench

- Display-side reader of the 320x240, 3-bit-colour framebuffer that the clear and tile-drawing blocks write through x/y/colour plot writes.
- Generates 640x480@60 VGA timing from the 50 MHz system clock using a 25 MHz pixel tick.
- Fetches framebuffer pixels through a 1-cycle-latency synchronous read port and outputs pixel-doubled RGB with aligned sync and blank.
- Also supplies frame timing (frame_start, vblank) so game logic updates tiles outside active video.

---
 rtl/vga_scanout_if.sv | 28 ++
 rtl/vga_scanout.sv | 141 ++++++++++++++
 tb/tb_vga_scanout.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Framebuffer read port and video output bundle for vga_scanout.
// The master side (scanout) drives the read request and all video/timing
// outputs; the slave side (framebuffer RAM / display sink) returns pixels.
interface vga_scanout_if;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vblank;
  logic        frame_start;

  modport master (
    output rd_addr, rd_en, vga_hs, vga_vs, vga_blank_n,
           vga_r, vga_g, vga_b, vblank, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_addr, rd_en, vga_hs, vga_vs, vga_blank_n,
           vga_r, vga_g, vga_b, vblank, frame_start,
    output rd_data
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout of a 320x240 3-bit framebuffer as pixel-doubled 640x480@60.
// A 25 MHz tick (every other 50 MHz clock) advances the raster counters.
// Each tick fetches the pixel under the counters; the following tick
// presents it together with sync and blank, so all video outputs lag the
// counters by exactly one tick.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          clock,
  input  logic          resetn,
  vga_scanout_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          phase_q;
  logic          tick_w;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          frame_start_q;

  logic          active_w, hs_w, vs_w;
  logic [16:0]   fy_w, fx_w, addr_w;

  logic [16:0]   rd_addr_q;
  logic          rd_en_q;
  logic          act_p1_q, hs_p1_q, vs_p1_q;

  logic          hs_q, vs_q, blank_n_q;
  logic [7:0]    r_q, g_q, b_q;

  assign tick_w = phase_q;

  // Raster position after the current one: wrap line, then frame.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      if (vcount_q == V_LAST) vcount_d = '0;
      else                    vcount_d = vcount_q + VW'(1);
    end else begin
      hcount_d = hcount_q + HW'(1);
    end
  end

  // Fetch-stage decode: framebuffer address (y*320 as shift-add) and sync windows.
  always_comb begin
    active_w = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hs_w     = !((hcount_q >= H_HS0) && (hcount_q < H_HS1));
    vs_w     = !((vcount_q >= V_VS0) && (vcount_q < V_VS1));
    fy_w     = 17'(vcount_q >> 1);
    fx_w     = 17'(hcount_q >> 1);
    addr_w   = (fy_w << 8) + (fy_w << 6) + fx_w;
  end

  // Pixel tick phase, raster counters and frame_start. frame_start is high
  // for the clock that ends in the tick processing position (0,0).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= ~phase_q;
      frame_start_q <= !phase_q && (hcount_q == '0) && (vcount_q == '0);
      if (tick_w) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
      end
    end
  end

  // Stage p1: issue the one-clock read strobe and carry sync/blank alongside it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      act_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
    end else if (tick_w) begin
      rd_en_q  <= active_w;
      if (active_w) rd_addr_q <= addr_w;
      act_p1_q <= active_w;
      hs_p1_q  <= hs_w;
      vs_p1_q  <= vs_w;
    end else begin
      rd_en_q <= 1'b0;
    end
  end

  // Stage p2: present the fetched pixel with its aligned sync and blank.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else if (tick_w) begin
      hs_q      <= hs_p1_q;
      vs_q      <= vs_p1_q;
      blank_n_q <= act_p1_q;
      r_q       <= act_p1_q ? {8{vif.rd_data[2]}} : 8'h00;
      g_q       <= act_p1_q ? {8{vif.rd_data[1]}} : 8'h00;
      b_q       <= act_p1_q ? {8{vif.rd_data[0]}} : 8'h00;
    end
  end

  assign vif.rd_addr     = rd_addr_q;
  assign vif.rd_en       = rd_en_q;
  assign vif.vga_hs      = hs_q;
  assign vif.vga_vs      = vs_q;
  assign vif.vga_blank_n = blank_n_q;
  assign vif.vga_r       = r_q;
  assign vif.vga_g       = g_q;
  assign vif.vga_b       = b_q;
  assign vif.vblank      = (vcount_q >= V_ACT);
  assign vif.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-timing instance checked cycle by cycle
// against a raster model driven by random framebuffer contents, plus a
// full-timing instance checked over its first three lines.
module tb_vga_scanout;
  localparam int S_HA  = 16;
  localparam int S_HFP = 4;
  localparam int S_HS  = 6;
  localparam int S_HBP = 4;
  localparam int S_VA  = 12;
  localparam int S_VFP = 2;
  localparam int S_VS  = 2;
  localparam int S_VBP = 3;
  localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FT  = S_HT * S_VT;

  logic clk;
  logic resetn;
  logic rstd_n;
  int   checks;
  int   errors;
  int   edge_k;
  logic [2:0] mem [0:76799];

  vga_scanout_if ifs ();
  vga_scanout_if ifd ();

  vga_scanout #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_dut (
    .clock (clk),
    .resetn(resetn),
    .vif   (ifs)
  );

  vga_scanout u_dut_full (
    .clock (clk),
    .resetn(rstd_n),
    .vif   (ifd)
  );

  assign ifd.rd_data = 3'b101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the last reset release (first edge after release is 0).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_k <= -1;
    else         edge_k <= edge_k + 1;
  end

  // Synchronous-read RAM model; returns garbage whenever not strobed.
  always @(posedge clk) begin
    if (ifs.rd_en) ifs.rd_data <= mem[ifs.rd_addr];
    else           ifs.rd_data <= 3'($urandom);
  end

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifs.rd_en, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n, ifs.vblank, ifs.frame_start} !== 6'b011000) begin
      errors++; $display("FAIL reset_ctrl got %b want 011000", {ifs.rd_en, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n, ifs.vblank, ifs.frame_start});
    end
    resetn = 1'b1;
    repeat ($urandom_range(300, 900)) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ifs.rd_en, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n, ifs.vblank, ifs.frame_start} !== 6'b011000) begin
      errors++; $display("FAIL midreset_ctrl got %b want 011000", {ifs.rd_en, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n, ifs.vblank, ifs.frame_start});
    end
    checks++;
    if (ifs.rd_addr !== 17'd0) begin
      errors++; $display("FAIL midreset_addr got %0d want 0", ifs.rd_addr);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifs.vga_r, ifs.vga_g, ifs.vga_b, ifs.rd_addr, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n} !== {24'h0, 17'd0, 3'b110}) begin
      errors++; $display("FAIL reset_hold got %h want %h", {ifs.vga_r, ifs.vga_g, ifs.vga_b, ifs.rd_addr, ifs.vga_hs, ifs.vga_vs, ifs.vga_blank_n}, {24'h0, 17'd0, 3'b110});
    end
    resetn = 1'b1;
  endtask

  task automatic test_frame(input int ncyc);
    int k, t, fh, fv, ph, pv, cpos, cv, a;
    logic e_en, e_hs, e_vs, e_bl, e_vb, e_fs;
    logic [7:0] e_r, e_g, e_b;
    logic [16:0] e_addr, last_addr;
    last_addr = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      k = edge_k;
      t = (k >= 1) ? (k - 1) / 2 : -1;
      e_en = 1'b0;
      if (k % 2 == 1) begin
        fh = t % S_HT;
        fv = (t / S_HT) % S_VT;
        if (fh < S_HA && fv < S_VA) begin
          e_en = 1'b1;
          last_addr = 17'((fv / 2) * 320 + fh / 2);
        end
      end
      e_addr = last_addr;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
      if (t >= 1) begin
        ph = (t - 1) % S_HT;
        pv = ((t - 1) / S_HT) % S_VT;
        e_hs = !(ph >= S_HA + S_HFP && ph < S_HA + S_HFP + S_HS);
        e_vs = !(pv >= S_VA + S_VFP && pv < S_VA + S_VFP + S_VS);
        if (ph < S_HA && pv < S_VA) begin
          e_bl = 1'b1;
          a = (pv / 2) * 320 + ph / 2;
          e_r = {8{mem[a][2]}};
          e_g = {8{mem[a][1]}};
          e_b = {8{mem[a][0]}};
        end
      end
      cpos = (k == 0) ? 0 : t + 1;
      cv = (cpos / S_HT) % S_VT;
      e_vb = (cv >= S_VA);
      e_fs = (k % 2 == 0) && ((k / 2) % S_FT == 0);

      checks++;
      if (ifs.rd_en !== e_en) begin errors++; $display("FAIL rd_en k=%0d got %b want %b", k, ifs.rd_en, e_en); end
      checks++;
      if (ifs.rd_addr !== e_addr) begin errors++; $display("FAIL rd_addr k=%0d got %0d want %0d", k, ifs.rd_addr, e_addr); end
      checks++;
      if (ifs.vga_hs !== e_hs) begin errors++; $display("FAIL hs k=%0d got %b want %b", k, ifs.vga_hs, e_hs); end
      checks++;
      if (ifs.vga_vs !== e_vs) begin errors++; $display("FAIL vs k=%0d got %b want %b", k, ifs.vga_vs, e_vs); end
      checks++;
      if (ifs.vga_blank_n !== e_bl) begin errors++; $display("FAIL blank_n k=%0d got %b want %b", k, ifs.vga_blank_n, e_bl); end
      checks++;
      if ({ifs.vga_r, ifs.vga_g, ifs.vga_b} !== {e_r, e_g, e_b}) begin
        errors++; $display("FAIL rgb k=%0d got %h want %h", k, {ifs.vga_r, ifs.vga_g, ifs.vga_b}, {e_r, e_g, e_b});
      end
      checks++;
      if (ifs.vblank !== e_vb) begin errors++; $display("FAIL vblank k=%0d got %b want %b", k, ifs.vblank, e_vb); end
      checks++;
      if (ifs.frame_start !== e_fs) begin errors++; $display("FAIL frame_start k=%0d got %b want %b", k, ifs.frame_start, e_fs); end
    end
  endtask

  task automatic test_frame_timing();
    int period, width, vb;
    bit seen, prev, cur;
    seen = 1'b0;
    for (int n = 0; n < 4 * S_FT && !seen; n++) begin
      @(negedge clk);
      if (ifs.frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL fs_seen got 0 want 1");
    end else begin
      period = 0; width = 0; vb = 0; prev = 1'b0;
      for (int i = 0; i < 4 * S_FT; i++) begin
        cur = ifs.frame_start;
        if (i > 0 && cur && !prev) break;
        if (cur) width++;
        if (ifs.vblank) vb++;
        period++;
        prev = cur;
        @(negedge clk);
      end
      checks++;
      if (period != 2 * S_FT) begin errors++; $display("FAIL fs_period got %0d want %0d", period, 2 * S_FT); end
      checks++;
      if (width != 1) begin errors++; $display("FAIL fs_width got %0d want 1", width); end
      checks++;
      if (vb != 2 * S_HT * (S_VT - S_VA)) begin errors++; $display("FAIL vblank_clocks got %0d want %0d", vb, 2 * S_HT * (S_VT - S_VA)); end
    end
  endtask

  task automatic test_default_lines();
    int kd, t, h, v, p, hs_low, bl_hi;
    logic e_en, e_hs, e_bl;
    hs_low = 0; bl_hi = 0; kd = -1;
    @(negedge clk);
    rstd_n = 1'b1;
    for (int i = 0; i < 2 * 800 * 3; i++) begin
      @(posedge clk);
      kd++;
      @(negedge clk);
      if (kd % 2 == 1) begin
        t = (kd - 1) / 2;
        h = t % 800;
        v = t / 800;
        e_en = (h < 640) && (v < 480);
        checks++;
        if (ifd.rd_en !== e_en) begin errors++; $display("FAIL full_rd_en h=%0d v=%0d got %b want %b", h, v, ifd.rd_en, e_en); end
        if (e_en) begin
          checks++;
          if (ifd.rd_addr !== 17'((v / 2) * 320 + h / 2)) begin
            errors++; $display("FAIL full_rd_addr h=%0d v=%0d got %0d want %0d", h, v, ifd.rd_addr, (v / 2) * 320 + h / 2);
          end
        end
        if (t >= 1) begin
          p = (t - 1) % 800;
          e_hs = !(p >= 656 && p < 752);
          e_bl = (p < 640);
          checks++;
          if ({ifd.vga_hs, ifd.vga_blank_n} !== {e_hs, e_bl}) begin
            errors++; $display("FAIL full_sync p=%0d got %b want %b", p, {ifd.vga_hs, ifd.vga_blank_n}, {e_hs, e_bl});
          end
          checks++;
          if ({ifd.vga_r, ifd.vga_g, ifd.vga_b} !== (e_bl ? 24'hFF00FF : 24'h0)) begin
            errors++; $display("FAIL full_rgb p=%0d got %h want %h", p, {ifd.vga_r, ifd.vga_g, ifd.vga_b}, (e_bl ? 24'hFF00FF : 24'h0));
          end
          if (t - 1 < 800) begin
            if (!ifd.vga_hs) hs_low++;
            if (ifd.vga_blank_n) bl_hi++;
          end
        end
      end else begin
        checks++;
        if (ifd.rd_en !== 1'b0) begin errors++; $display("FAIL full_rd_en_width kd=%0d got %b want 0", kd, ifd.rd_en); end
      end
    end
    checks++;
    if (hs_low != 96) begin errors++; $display("FAIL full_hs_ticks got %0d want 96", hs_low); end
    checks++;
    if (bl_hi != 640) begin errors++; $display("FAIL full_blank_ticks got %0d want 640", bl_hi); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    rstd_n = 1'b0;
    for (int i = 0; i < 76800; i++) mem[i] = 3'($urandom);
    test_reset();
    test_frame(2 * S_FT * 2 + 100);
    test_frame_timing();
    test_default_lines();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
